// File: rtl/alu_muldiv_ctrl.sv
// alu_muldiv_ctrl: registered ALU-control decode plus an iterative signed MULT/DIV engine with HI/LO.
// Build macro ALU_MULDIV_UNSIGNED_EN adds MULTU/DIVU on the same engine.
module alu_muldiv_ctrl #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        alu_opcode,
    input  logic [5:0]        func,
    input  logic [WIDTH-1:0]  op_a,
    input  logic [WIDTH-1:0]  op_b,
    output logic              out_valid,
    output logic [CTRL_W-1:0] alu_control,
    output logic [WIDTH-1:0]  hi,
    output logic [WIDTH-1:0]  lo,
    output logic              stall,
    output logic              div_zero
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, BUSY, FIX} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                out_valid_q, out_valid_d;
    logic                div_zero_q, div_zero_d;
    logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
    logic [WIDTH-1:0]    hi_q, hi_d, lo_q, lo_d;
    logic                is_div_q, is_div_d;
    logic                negq_q, negq_d;
    logic                negr_q, negr_d;
    logic                dz_q, dz_d;
    logic [WIDTH-1:0]    acc_q, acc_d, mq_q, mq_d, mcand_q, mcand_d;

    function automatic logic [4:0] decode(input logic [3:0] opc, input logic [5:0] fn);
        logic [4:0] c;
        c = 5'h00;
        if (opc == 4'd0) begin
            case (fn)
                6'b100110: c = 5'h00;
                6'b000000: c = 5'h01;
                6'b000100: c = 5'h02;
                6'b000010: c = 5'h03;
                6'b100010: c = 5'h04;
                6'b000110: c = 5'h05;
                6'b101010: c = 5'h06;
                6'b001100: c = 5'h07;
                6'b100011: c = 5'h08;
                6'b100101: c = 5'h09;
                6'b100111: c = 5'h0A;
                6'b100001: c = 5'h0B;
                6'b011000: c = 5'h0C;
                6'b011010: c = 5'h0D;
                6'b100100: c = 5'h0E;
                6'b100000: c = 5'h0F;
                6'b000011: c = 5'h10;
`ifdef ALU_MULDIV_UNSIGNED_EN
                6'b011001: c = 5'h17;
                6'b011011: c = 5'h18;
`endif
                default:   c = 5'h00;
            endcase
        end else begin
            case (opc)
                4'd1:    c = 5'h0F;
                4'd2:    c = 5'h0E;
                4'd3:    c = 5'h00;
                4'd4:    c = 5'h09;
                4'd5:    c = 5'h11;
                4'd6:    c = 5'h12;
                4'd7:    c = 5'h13;
                4'd8:    c = 5'h14;
                4'd9:    c = 5'h15;
                4'd10:   c = 5'h06;
                4'd11:   c = 5'h16;
                default: c = 5'h00;
            endcase
        end
        return c;
    endfunction

    function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] x, input logic n);
        return n ? -x : x;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg2_if(input logic [2*WIDTH-1:0] x, input logic n);
        return n ? -x : x;
    endfunction

    logic             is_mul_op, is_div_op, op_unsigned;
    logic             sgn_a, sgn_b;
    logic [WIDTH-1:0] mag_a, mag_b;

    always_comb begin
        is_mul_op   = (alu_opcode == 4'd0) && (func == 6'b011000);
        is_div_op   = (alu_opcode == 4'd0) && (func == 6'b011010);
        op_unsigned = 1'b0;
`ifdef ALU_MULDIV_UNSIGNED_EN
        if ((alu_opcode == 4'd0) && (func == 6'b011001)) begin
            is_mul_op   = 1'b1;
            op_unsigned = 1'b1;
        end
        if ((alu_opcode == 4'd0) && (func == 6'b011011)) begin
            is_div_op   = 1'b1;
            op_unsigned = 1'b1;
        end
`endif
        sgn_a = ~op_unsigned & op_a[WIDTH-1];
        sgn_b = ~op_unsigned & op_b[WIDTH-1];
        mag_a = neg_if(op_a, sgn_a);
        mag_b = neg_if(op_b, sgn_b);
    end

    // One iteration step: shift-add for MULT, restoring shift-subtract for DIV
    logic [WIDTH:0]   mul_sum, div_shift, div_diff;
    logic [WIDTH-1:0] mul_acc, mul_mq, div_acc, div_mq;

    always_comb begin
        mul_sum   = mq_q[0] ? ({1'b0, acc_q} + {1'b0, mcand_q}) : {1'b0, acc_q};
        mul_acc   = mul_sum[WIDTH:1];
        mul_mq    = {mul_sum[0], mq_q[WIDTH-1:1]};
        div_shift = {acc_q, mq_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, mcand_q};
        if (!div_diff[WIDTH]) begin
            div_acc = div_diff[WIDTH-1:0];
            div_mq  = {mq_q[WIDTH-2:0], 1'b1};
        end else begin
            div_acc = div_shift[WIDTH-1:0];
            div_mq  = {mq_q[WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_valid_d = 1'b0;
        div_zero_d  = 1'b0;
        ctrl_d      = ctrl_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        is_div_d    = is_div_q;
        negq_d      = negq_q;
        negr_d      = negr_q;
        dz_d        = dz_q;
        acc_d       = acc_q;
        mq_d        = mq_q;
        mcand_d     = mcand_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    ctrl_d = CTRL_W'(decode(alu_opcode, func));
                    if (is_mul_op || is_div_op) begin
                        is_div_d = is_div_op;
                        negq_d   = sgn_a ^ sgn_b;
                        negr_d   = sgn_a;
                        cnt_d    = CNT_W'(WIDTH);
                        acc_d    = '0;
                        mcand_d  = is_div_op ? mag_b : mag_a;
                        mq_d     = is_div_op ? mag_a : mag_b;
                        dz_d     = is_div_op && (op_b == '0);
                        // Divide by zero skips iteration; mq carries raw op_a into HI
                        if (is_div_op && (op_b == '0)) begin
                            mq_d    = op_a;
                            state_d = FIX;
                        end else begin
                            state_d = BUSY;
                        end
                    end else begin
                        out_valid_d = 1'b1;
                    end
                end
            end
            BUSY: begin
                acc_d = is_div_q ? div_acc : mul_acc;
                mq_d  = is_div_q ? div_mq  : mul_mq;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = FIX;
            end
            FIX: begin
                out_valid_d = 1'b1;
                div_zero_d  = dz_q;
                state_d     = IDLE;
                if (dz_q) begin
                    hi_d = mq_q;
                    lo_d = '1;
                end else if (is_div_q) begin
                    lo_d = neg_if(mq_q, negq_q);
                    hi_d = neg_if(acc_q, negr_q);
                end else begin
                    {hi_d, lo_d} = neg2_if({acc_q, mq_q}, negq_q);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            div_zero_q  <= 1'b0;
            ctrl_q      <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            is_div_q    <= 1'b0;
            negq_q      <= 1'b0;
            negr_q      <= 1'b0;
            dz_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            div_zero_q  <= div_zero_d;
            ctrl_q      <= ctrl_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            is_div_q    <= is_div_d;
            negq_q      <= negq_d;
            negr_q      <= negr_d;
            dz_q        <= dz_d;
        end
    end

    // Iteration working registers are only meaningful after a load, so they carry no reset
    always_ff @(posedge clk) begin
        acc_q   <= acc_d;
        mq_q    <= mq_d;
        mcand_q <= mcand_d;
    end

    assign in_ready    = (state_q == IDLE);
    assign stall       = (state_q != IDLE);
    assign out_valid   = out_valid_q;
    assign div_zero    = div_zero_q;
    assign alu_control = ctrl_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_alu_muldiv_ctrl.sv
// Directed bench for alu_muldiv_ctrl (WIDTH=32); honours ALU_MULDIV_UNSIGNED_EN when defined.
module tb_alu_muldiv_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_opcode;
    logic [5:0]  func;
    logic [31:0] op_a, op_b;
    logic        out_valid;
    logic [4:0]  alu_control;
    logic [31:0] hi, lo;
    logic        stall;
    logic        div_zero;

    int checks = 0;
    int errors = 0;
    int lat, stalls, pulses;

    alu_muldiv_ctrl #(.WIDTH(32), .CTRL_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_opcode(alu_opcode), .func(func), .op_a(op_a), .op_b(op_b),
        .out_valid(out_valid), .alu_control(alu_control), .hi(hi), .lo(lo),
        .stall(stall), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Presents one op, returns edges after the accept edge until out_valid and stalled cycles seen.
    task automatic do_op(input logic [3:0] opc, input logic [5:0] fn,
                         input logic [31:0] a, input logic [31:0] b, input bit inject,
                         output int lat_o, output int stalls_o);
        alu_opcode = opc; func = fn; op_a = a; op_b = b; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        lat_o = 0;
        stalls_o = 0;
        while (!out_valid && lat_o < 100) begin
            if (stall) stalls_o++;
            if (inject && lat_o == 5) begin
                alu_opcode = 4'd0; func = 6'b100000; in_valid = 1'b1;
            end
            if (inject && lat_o == 8) in_valid = 1'b0;
            tick;
            lat_o++;
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; alu_opcode = '0; func = '0; op_a = '0; op_b = '0;
        tick; tick;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_ctrl", alu_control, 0);
        chk("rst_hilo", {hi, lo}, 0);
        chk("rst_stall_dz", {stall, div_zero}, 0);
        rst_n = 1'b1;
        tick;

        do_op(4'd0, 6'b100000, 32'd0, 32'd0, 0, lat, stalls);
        chk("add_lat", lat, 0);
        chk("add_ctrl", alu_control, 5'h0F);
        chk("add_stall", stall, 0);

        alu_opcode = 4'd4; in_valid = 1'b1;
        tick;
        chk("ori_ctrl", {out_valid, in_ready, alu_control}, {2'b11, 5'h09});
        alu_opcode = 4'd5;
        tick;
        chk("beq_ctrl", {out_valid, in_ready, alu_control}, {2'b11, 5'h11});
        alu_opcode = 4'd10;
        tick;
        chk("slti_ctrl", {out_valid, in_ready, alu_control}, {2'b11, 5'h06});
        in_valid = 1'b0;
        tick;
        chk("idle_no_valid", out_valid, 0);

        // Accept edge counts as edge 1, so out_valid at edge 34 is 33 edges after it
        do_op(4'd0, 6'b011000, 32'd7, 32'hFFFF_FFFD, 1, lat, stalls);
        chk("mult_lat", lat, 33);
        chk("mult_stalls", stalls, 33);
        chk("mult_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        chk("mult_ctrl", alu_control, 5'h0C);
        chk("mult_ready", {in_ready, stall, div_zero}, 3'b100);
        tick;
        chk("mult_pulse_once", out_valid, 0);

        do_op(4'd0, 6'b011010, 32'hFFFF_FFF9, 32'd2, 0, lat, stalls);
        chk("div_neg_lat", lat, 33);
        chk("div_neg_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        chk("div_neg_ctrl", {alu_control, div_zero}, {5'h0D, 1'b0});

        do_op(4'd0, 6'b011010, 32'h8000_0000, 32'hFFFF_FFFF, 0, lat, stalls);
        chk("div_ovf_hilo", {hi, lo}, 64'h0000_0000_8000_0000);

        do_op(4'd0, 6'b011010, 32'd5, 32'd0, 0, lat, stalls);
        chk("dz_lat", lat, 1);
        chk("dz_flag", div_zero, 1);
        chk("dz_hilo", {hi, lo}, 64'h0000_0005_FFFF_FFFF);
        tick;
        chk("dz_flag_pulse", {div_zero, out_valid}, 0);

        do_op(4'd0, 6'b100000, 32'd9, 32'd9, 0, lat, stalls);
        chk("hold_hilo", {hi, lo}, 64'h0000_0005_FFFF_FFFF);

        alu_opcode = 4'd0; func = 6'b011000; op_a = 32'd123; op_b = 32'd456; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) tick;
        chk("mid_stall", stall, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ctl", {stall, in_ready, out_valid}, 3'b010);
        chk("mid_rst_hilo", {hi, lo}, 0);
        tick;
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) pulses++;
            tick;
        end
        chk("mid_rst_no_pulse", pulses, 0);
        do_op(4'd0, 6'b100000, 32'd0, 32'd0, 0, lat, stalls);
        chk("post_rst_add", {lat[7:0], alu_control}, {8'd0, 5'h0F});

        do_op(4'd0, 6'b011010, 32'd5, 32'd0, 0, lat, stalls);
        do_op(4'd0, 6'b011001, 32'hFFFF_FFFF, 32'd2, 0, lat, stalls);
`ifdef ALU_MULDIV_UNSIGNED_EN
        chk("multu_lat", lat, 33);
        chk("multu_hilo", {hi, lo}, 64'h0000_0001_FFFF_FFFE);
        chk("multu_ctrl", alu_control, 5'h17);
`else
        chk("multu_lat", lat, 0);
        chk("multu_stalls", stalls, 0);
        chk("multu_hilo", {hi, lo}, 64'h0000_0005_FFFF_FFFF);
        chk("multu_ctrl", alu_control, 5'h00);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
